button_debouncer: RTL and testbench

- Cleans a raw mechanical push-button input and produces a debounced level plus single-cycle edge pulses.
- Sits directly upstream of the 2-bit counter: btn_rise is the counter's advance/enable strobe, so one physical press gives exactly one count step.
- Fully synchronous to clk except for the asynchronous input synchroniser and the asynchronous reset.

---
 rtl/debounce_pkg.sv | 17 +
 rtl/sync_chain.sv | 25 ++
 rtl/button_debouncer.sv | 105 ++++++++++
 tb/tb_button_debouncer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encodings and
// the counter-width helper used to size the stability counter.
package debounce_pkg;

    // Debouncer FSM states: two settled levels and two qualification windows.
    localparam logic [1:0] IDLE_LOW  = 2'd0;
    localparam logic [1:0] WAIT_HIGH = 2'd1;
    localparam logic [1:0] IDLE_HIGH = 2'd2;
    localparam logic [1:0] WAIT_LOW  = 2'd3;

    // Width able to hold the value stable_cycles (the counter itself never
    // exceeds stable_cycles-1, the extra headroom keeps comparisons simple).
    function automatic int cnt_width(input int stable_cycles);
        return $clog2(stable_cycles + 1);
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for a single asynchronous input bit. Plain shift
// chain with no logic between stages so metastability can settle.
module sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic [SYNC_STAGES-1:0] stages;

    // Shift the raw input through the chain; async clear to 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stages <= '0;
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], din};
        end
    end

    assign dout = stages[SYNC_STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Push-button debouncer: synchronises the raw button, requires STABLE_CYCLES
// consecutive identical samples before accepting a new level, and emits a
// registered one-cycle pulse on each accepted press (btn_rise) or release
// (btn_fall). btn_rise drives the downstream counter's advance strobe.
module button_debouncer
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = 1000000,
    parameter int SYNC_STAGES   = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_rise,
    output logic btn_fall
);

    localparam int               CNT_W    = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             sync_q;
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;

    sync_chain #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .din  (btn_in),
        .dout (sync_q)
    );

    // Qualification FSM: the IDLE state counts as the first sample at the new
    // value, so a change is accepted on the STABLE_CYCLES-th identical sample.
    // Any disagreeing sample aborts the window back to the settled state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE_LOW;
            cnt       <= '0;
            btn_level <= 1'b0;
            btn_rise  <= 1'b0;
            btn_fall  <= 1'b0;
        end else begin
            btn_rise <= 1'b0;
            btn_fall <= 1'b0;
            case (state)
                IDLE_LOW: begin
                    if (sync_q) begin
                        state <= WAIT_HIGH;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt   <= '0;
                    end
                end
                WAIT_HIGH: begin
                    if (sync_q) begin
                        if (cnt == CNT_LAST) begin
                            state     <= IDLE_HIGH;
                            btn_level <= 1'b1;
                            btn_rise  <= 1'b1;
                            cnt       <= '0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end else begin
                        state <= IDLE_LOW;
                        cnt   <= '0;
                    end
                end
                IDLE_HIGH: begin
                    if (!sync_q) begin
                        state <= WAIT_LOW;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt   <= '0;
                    end
                end
                WAIT_LOW: begin
                    if (!sync_q) begin
                        if (cnt == CNT_LAST) begin
                            state     <= IDLE_LOW;
                            btn_level <= 1'b0;
                            btn_fall  <= 1'b1;
                            cnt       <= '0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end else begin
                        state <= IDLE_HIGH;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state     <= IDLE_LOW;
                    cnt       <= '0;
                    btn_level <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Testbench for button_debouncer with STABLE_CYCLES=4, SYNC_STAGES=2.
// A reference model derives expected outputs from the raw input history:
// the synchroniser is a pure SYNC_STAGES-sample delay, and a new level is
// accepted once that delayed input has disagreed with the current level for
// STABLE_CYCLES consecutive samples.
module tb_button_debouncer;

    localparam int STABLE = 4;
    localparam int SYNC   = 2;

    logic clk = 1'b0;
    logic reset;
    logic btn_in;
    logic btn_level;
    logic btn_rise;
    logic btn_fall;

    int errors = 0;
    int checks = 0;

    button_debouncer #(
        .STABLE_CYCLES(STABLE),
        .SYNC_STAGES  (SYNC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_in   (btn_in),
        .btn_level(btn_level),
        .btn_rise (btn_rise),
        .btn_fall (btn_fall)
    );

    always #5 clk = ~clk;

    // Downstream 2-bit press counter advanced by btn_rise.
    logic [1:0] press_cnt;
    always @(posedge clk or negedge reset) begin
        if (!reset) press_cnt <= 2'd0;
        else if (btn_rise) press_cnt <= press_cnt + 2'd1;
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
        int   run;
    } mstate_t;

    mstate_t m;
    logic    hist[$];

    // Synchronised value visible at this edge: the raw input captured SYNC edges ago.
    function automatic logic sync_seen();
        if (hist.size() >= SYNC) return hist[hist.size() - SYNC];
        return 1'b0;
    endfunction

    function automatic mstate_t model_next(input logic s, input mstate_t cur);
        mstate_t n;
        n      = cur;
        n.rise = 1'b0;
        n.fall = 1'b0;
        if (s != cur.level) begin
            n.run = cur.run + 1;
            if (n.run == STABLE) begin
                n.level = s;
                n.rise  = s;
                n.fall  = !s;
                n.run   = 0;
            end
        end else begin
            n.run = 0;
        end
        return n;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m <= '0;
            hist.delete();
        end else begin
            m <= model_next(sync_seen(), m);
            hist.push_back(btn_in);
            if (hist.size() > 16) hist.pop_front();
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b0;
        repeat (n) @(negedge clk);
        reset = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        btn_in = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checks++;
            if ({btn_level, btn_rise, btn_fall} !== 3'b000) begin
                errors++;
                $display("FAIL reset cyc=%0d: level/rise/fall=%b%b%b, want 000", k, btn_level, btn_rise, btn_fall);
            end
        end
        btn_in = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_clean_press();
        do_reset(2);
        btn_in = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checks++;
            if (btn_level !== (k >= 6) || btn_rise !== (k == 6) || btn_fall !== 1'b0) begin
                errors++;
                $display("FAIL clean_press edge=%0d: level=%b rise=%b fall=%b, want level=%b rise=%b fall=0",
                         k, btn_level, btn_rise, btn_fall, (k >= 6), (k == 6));
            end
            checks++;
            if ({btn_level, btn_rise, btn_fall} !== {m.level, m.rise, m.fall}) begin
                errors++;
                $display("FAIL clean_press_model edge=%0d: got %b%b%b, want %b%b%b",
                         k, btn_level, btn_rise, btn_fall, m.level, m.rise, m.fall);
            end
        end
    endtask

    task automatic test_release();
        btn_in = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checks++;
            if (btn_level !== (k < 6) || btn_fall !== (k == 6) || btn_rise !== 1'b0) begin
                errors++;
                $display("FAIL release edge=%0d: level=%b rise=%b fall=%b, want level=%b rise=0 fall=%b",
                         k, btn_level, btn_rise, btn_fall, (k < 6), (k == 6));
            end
            checks++;
            if ({btn_level, btn_rise, btn_fall} !== {m.level, m.rise, m.fall}) begin
                errors++;
                $display("FAIL release_model edge=%0d: got %b%b%b, want %b%b%b",
                         k, btn_level, btn_rise, btn_fall, m.level, m.rise, m.fall);
            end
        end
    endtask

    task automatic test_bounce();
        // 1,1,1,0 then held 1: the 0 aborts the window, acceptance on edge 10
        for (int k = 1; k <= 12; k++) begin
            btn_in = (k == 4) ? 1'b0 : 1'b1;
            @(negedge clk);
            checks++;
            if (btn_level !== (k >= 10) || btn_rise !== (k == 10) || btn_fall !== 1'b0) begin
                errors++;
                $display("FAIL bounce edge=%0d: level=%b rise=%b fall=%b, want level=%b rise=%b fall=0",
                         k, btn_level, btn_rise, btn_fall, (k >= 10), (k == 10));
            end
            checks++;
            if ({btn_level, btn_rise, btn_fall} !== {m.level, m.rise, m.fall}) begin
                errors++;
                $display("FAIL bounce_model edge=%0d: got %b%b%b, want %b%b%b",
                         k, btn_level, btn_rise, btn_fall, m.level, m.rise, m.fall);
            end
        end
    endtask

    task automatic test_counter();
        btn_in = 1'b0;
        do_reset(2);
        checks++;
        if (press_cnt !== 2'd0) begin
            errors++;
            $display("FAIL counter_start: count=%0d, want 0", press_cnt);
        end
        for (int p = 1; p <= 3; p++) begin
            if (p == 3) begin
                btn_in = 1'b1;
                repeat (3) @(negedge clk);
                btn_in = 1'b0;
                repeat (8) @(negedge clk);
                checks++;
                if (press_cnt !== 2'd2 || btn_level !== 1'b0) begin
                    errors++;
                    $display("FAIL counter_glitch: count=%0d level=%b, want count=2 level=0", press_cnt, btn_level);
                end
            end
            btn_in = 1'b1;
            repeat (8) @(negedge clk);
            checks++;
            if (press_cnt !== 2'(p) || btn_level !== 1'b1) begin
                errors++;
                $display("FAIL counter_press%0d: count=%0d level=%b, want count=%0d level=1", p, press_cnt, btn_level, p);
            end
            btn_in = 1'b0;
            repeat (8) @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        // Reset in the middle of the WAIT_HIGH window
        btn_in = 1'b0;
        do_reset(2);
        btn_in = 1'b1;
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({btn_level, btn_rise, btn_fall} !== 3'b000) begin
            errors++;
            $display("FAIL async_mid_window: got %b%b%b, want 000", btn_level, btn_rise, btn_fall);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            checks++;
            if (btn_level !== (k >= 6) || btn_rise !== (k == 6)) begin
                errors++;
                $display("FAIL async_relatency edge=%0d: level=%b rise=%b, want level=%b rise=%b",
                         k, btn_level, btn_rise, (k >= 6), (k == 6));
            end
        end
        // Reset while a rise pulse is in flight
        do_reset(1);
        btn_in = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (btn_rise !== 1'b1) begin
            errors++;
            $display("FAIL pulse_before_kill: rise=%b, want 1", btn_rise);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({btn_level, btn_rise, btn_fall} !== 3'b000) begin
            errors++;
            $display("FAIL pulse_kill: got %b%b%b, want 000", btn_level, btn_rise, btn_fall);
        end
        @(negedge clk);
        btn_in = 1'b0;
        reset  = 1'b1;
    endtask

    task automatic test_random();
        logic v;
        int   len;
        do_reset(1);
        for (int r = 0; r < 60; r++) begin
            v   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 7);
            for (int c = 0; c < len; c++) begin
                btn_in = v;
                @(negedge clk);
                checks++;
                if ({btn_level, btn_rise, btn_fall} !== {m.level, m.rise, m.fall}) begin
                    errors++;
                    $display("FAIL random run=%0d: got %b%b%b, want %b%b%b",
                             r, btn_level, btn_rise, btn_fall, m.level, m.rise, m.fall);
                end
                checks++;
                if (btn_rise === 1'b1 && btn_fall === 1'b1) begin
                    errors++;
                    $display("FAIL random_both_pulses run=%0d: rise=1 fall=1, want not both", r);
                end
            end
        end
    endtask

    initial begin
        reset  = 1'b1;
        btn_in = 1'b0;
        test_reset();
        test_clean_press();
        test_release();
        test_bounce();
        test_counter();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
